// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus per-bit stability counter for the slide-switch bank.
// Level and rise/fall pulses appear DEBOUNCE_CYCLES+2 edges after the pin settles; no backpressure, outputs are level/pulse only.
module switch_debouncer #(
  parameter int N               = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] SW,
  output logic [N-1:0] sw_clean,
  output logic [N-1:0] sw_rise,
  output logic [N-1:0] sw_fall,
  output logic         sw_changed
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } slice_state_t;

  logic [N-1:0]     s1;
  logic [N-1:0]     s2;
  logic [CNT_W-1:0] cnt     [N];
  logic [CNT_W-1:0] cnt_nxt [N];
  slice_state_t     state   [N];
  logic [N-1:0]     clean_nxt;
  logic [N-1:0]     rise_nxt;
  logic [N-1:0]     fall_nxt;
  logic             changed_nxt;

  // A slice is counting whenever the synchronized pin disagrees with the
  // accepted level; agreeing again at any point restarts the stability timer.
  always_comb begin
    clean_nxt = sw_clean;
    rise_nxt  = '0;
    fall_nxt  = '0;
    for (int i = 0; i < N; i++) begin
      cnt_nxt[i] = '0;
      state[i]   = (s2[i] != sw_clean[i]) ? COUNTING : IDLE;
      if (state[i] == COUNTING) begin
        if (cnt[i] == CNT_MAX) begin
          clean_nxt[i] = s2[i];
          rise_nxt[i]  = s2[i];
          fall_nxt[i]  = ~s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
    changed_nxt = |(rise_nxt | fall_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1         <= '0;
      s2         <= '0;
      sw_clean   <= '0;
      sw_rise    <= '0;
      sw_fall    <= '0;
      sw_changed <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1         <= SW;
      s2         <= s1;
      sw_clean   <= clean_nxt;
      sw_rise    <= rise_nxt;
      sw_fall    <= fall_nxt;
      sw_changed <= changed_nxt;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench: a sliding-window stability model predicts every cycle's outputs; a negedge monitor compares.
module tb_switch_debouncer;

  localparam int N = 10;
  localparam int D = 4;

  typedef struct packed {
    logic [N-1:0] clean;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic         changed;
  } obs_t;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] SW;
  logic [N-1:0] sw_clean;
  logic [N-1:0] sw_rise;
  logic [N-1:0] sw_fall;
  logic         sw_changed;

  int checks = 0;
  int errors = 0;
  obs_t exp_q[$];

  switch_debouncer #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .SW         (SW),
    .sw_clean   (sw_clean),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .sw_changed (sw_changed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: the pin reaches the debounce stage two clocks late; the level
  // flips once the last D delayed samples since reset all disagree with it.
  initial begin
    logic [N-1:0] m_s1, m_s2, m_clean, er, ef;
    logic [N-1:0] hist[$];
    obs_t o;
    bit all_diff;
    m_s1 = '0; m_s2 = '0; m_clean = '0;
    forever begin
      @(posedge clk);
      er = '0;
      ef = '0;
      if (!rst_n) begin
        m_s1 = '0; m_s2 = '0; m_clean = '0;
        hist.delete();
      end else begin
        hist.push_back(m_s2);
        if (hist.size() > D) void'(hist.pop_front());
        if (hist.size() == D) begin
          for (int i = 0; i < N; i++) begin
            all_diff = 1'b1;
            foreach (hist[j]) if (hist[j][i] == m_clean[i]) all_diff = 1'b0;
            if (all_diff) begin
              m_clean[i] = ~m_clean[i];
              if (m_clean[i]) er[i] = 1'b1; else ef[i] = 1'b1;
            end
          end
        end
        m_s2 = m_s1;
        m_s1 = SW;
      end
      o.clean   = m_clean;
      o.rise    = er;
      o.fall    = ef;
      o.changed = |(er | ef);
      exp_q.push_back(o);
    end
  end

  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{clean: sw_clean, rise: sw_rise, fall: sw_fall, changed: sw_changed};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got clean=%h rise=%h fall=%h chg=%b expected clean=%h rise=%h fall=%h chg=%b",
                   $time, a.clean, a.rise, a.fall, a.changed, e.clean, e.rise, e.fall, e.changed);
        end
      end
    end
  end

  task automatic step(input logic [N-1:0] sw, input logic rn, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
      SW    = sw;
      rst_n = rn;
    end
  endtask

  initial begin
    logic [N-1:0] cur;
    SW    = '1;
    rst_n = 1'b0;
    // Reset with all pins high, then release: full-width rise after latency.
    step(10'h3FF, 1'b0, 3);
    step(10'h3FF, 1'b1, 12);
    // Settle low, then a clean press on bit 0.
    step(10'h000, 1'b1, 10);
    step(10'h001, 1'b1, 10);
    // Bounce on bit 3 shorter than the stability window.
    step(10'h009, 1'b1, 2);
    step(10'h001, 1'b1, 2);
    step(10'h009, 1'b1, 2);
    step(10'h001, 1'b1, 12);
    // Simultaneous fall on bit 1 and rise on bit 8.
    step(10'h002, 1'b1, 12);
    step(10'h100, 1'b1, 12);
    // Reset aborts an in-progress count on bit 5.
    step(10'h000, 1'b1, 12);
    step(10'h020, 1'b1, 3);
    step(10'h020, 1'b0, 1);
    step(10'h020, 1'b1, 12);
    // Long hold on bit 9.
    step(10'h220, 1'b1, 1000);
    // Randomized pin activity with occasional resets.
    cur = 10'h220;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(7, 0) == 0) cur[$urandom_range(N - 1, 0)] ^= 1'b1;
      if ($urandom_range(15, 0) == 0) cur = cur ^ N'($urandom());
      step(cur, ($urandom_range(299, 0) != 0), 1);
    end
    step(cur, 1'b1, 10);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
